aes_round_sched: RTL
====================

Name: aes_round_sched

Overview:
- Sequencer sitting between the host and the AES key-expansion/round datapath.
- Loads a cipher key into Key_Expansion by pulsing its k_ready with a validated Nk, then waits for the expansion to settle.
- Per data block, walks the round-key address Addr through rounds 0..Nr and issues one round-enable per round, with the round type.
- Presents a valid/ready handshake to the host on both the input and output side.

Parameters:
- KEY_WAIT, 16, cycles to wait after the k_ready pulse before round keys are treated as usable (1..255).
- ADDR_W, 4, width of the round-key address (must hold 14).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_load  in  1  request to load a new cipher key; single-cycle pulse.
- key_nk  in  4  key length in 32-bit words; legal values 4, 6, 8; sampled with key_load.
- ke_k_ready  out  1  one-cycle pulse to Key_Expansion k_ready.
- ke_nk  out  4  Nk driven to Key_Expansion; registered.
- key_ok  out  1  key loaded and expansion settled; blocks may be accepted.
- key_err  out  1  sticky; last key_load carried an illegal key_nk.
- blk_valid  in  1  host offers a plaintext block.
- blk_ready  out  1  sequencer accepts a block this cycle.
- rk_addr  out  ADDR_W  round-key address to Key_Expansion Addr.
- rk_valid  in  1  round key at rk_addr is available this cycle.
- rnd_en  out  1  datapath performs one round this cycle.
- rnd_type  out  2  0 = initial AddRoundKey, 1 = middle round, 2 = final round (no MixColumns).
- out_valid  out  1  result block available.
- out_ready  in  1  host consumes the result.

Behaviour:
- Reset (async, any state) → state IDLE. All outputs are 0 at reset: ke_k_ready, ke_nk, key_ok, key_err, blk_ready, rk_addr, rnd_en, rnd_type, out_valid. Any in-flight block is dropped.
- Nr = key_nk + 6: 10, 12 or 14, computed as a registered 4-bit value at key load.
- States: IDLE, KLOAD, KWAIT, READY, ROUND, DONE.
- IDLE / READY, on key_load with a legal key_nk:
  - ke_nk <= key_nk; key_err <= 0; key_ok <= 0; enter KLOAD.
- IDLE / READY, on key_load with an illegal key_nk:
  - key_err <= 1; key_ok <= 0; enter IDLE.
- KLOAD: ke_k_ready = 1 for exactly this one cycle; wait counter <= KEY_WAIT-1; enter KWAIT.
- KWAIT: decrement the counter each cycle. At 0: key_ok <= 1; enter READY.
- key_load arriving in KLOAD, KWAIT, ROUND or DONE is ignored; no queueing.
- READY: blk_ready = 1 combinationally, only when key_ok = 1 and key_load = 0.
  - If blk_valid and key_load are both high in the same cycle, key_load wins and the block is not accepted.
  - On blk_valid & blk_ready: rk_addr <= 0; enter ROUND.
- ROUND: rk_addr holds the current round r.
  - rnd_en = rk_valid. rnd_type = 0 if r = 0, 2 if r = Nr, else 1.
  - While rk_valid = 0: stall, with rk_addr held and rnd_en = 0.
  - On rk_valid = 1 and r < Nr: rk_addr <= r+1.
  - On rk_valid = 1 and r = Nr: enter DONE.
- DONE: out_valid = 1; rk_addr holds Nr. On out_ready: out_valid <= 0; enter READY.
  - out_valid is held until out_ready; the block is never lost.
- Latency with rk_valid tied high: handshake at cycle 0 → rnd_en in cycles 1..Nr+1 → out_valid from cycle Nr+2. For AES-128 out_valid first asserts at cycle 12.
- Exactly Nr+1 rnd_en pulses per block. rk_addr never exceeds Nr and never wraps.
- Back-to-back blocks: out_ready in cycle t → READY in t+1; the next block can be accepted in t+1.

Optional Feature:
- Macro DECRYPT_EN.
- Defined:
  - Adds input port dec (1 bit), sampled at block accept.
  - With dec = 1, rk_addr walks Nr down to 0.
  - rnd_type = 0 at r = Nr, 2 at r = 0, else 1.
  - Termination is on the last step, r = 0.
- Not defined: no dec port; ascending order only.

Test Plan:
- Reset mid-ROUND (rk_addr = 5), rst high 1 cycle → all outputs 0 the same cycle, state IDLE, key_ok = 0.
- key_load with key_nk = 4, KEY_WAIT = 16 → ke_k_ready pulses exactly 1 cycle with ke_nk = 4; key_ok rises 17 cycles after the pulse; blk_ready follows.
- key_nk = 3 → no ke_k_ready pulse, key_err = 1, key_ok = 0. A following legal key_nk = 8 clears key_err.
- Nk = 4, rk_valid = 1, block at cycle 0 → rk_addr 0..10 over cycles 1..11; rnd_type 0,1×9,2; out_valid at cycle 12. Nk = 8 gives 15 rnd_en pulses.
- rk_valid low for 3 cycles at r = 4 → rk_addr held at 4 with rnd_en = 0; total latency +3.
- out_ready held low 5 cycles → out_valid held, blk_ready = 0; simultaneous blk_valid + key_load in READY → key reload starts, block not accepted.

Source files
------------

// File: rtl/aes_round_sched.sv
// aes_round_sched
// ---------------------------------------------------------------------------
// Sequencer between the host and the AES key-expansion / round datapath.
// A key load pulses Key_Expansion's k_ready with a validated Nk, then waits
// KEY_WAIT cycles for the expansion to settle before blocks are accepted.
// Each accepted block walks the round-key address through every round,
// issuing one round-enable per available round key together with the round
// type, and then holds the result until the host consumes it.
//
// Parameters:
//   KEY_WAIT  settle cycles after the k_ready pulse (1..255)
//   ADDR_W    round-key address width (must hold 14)
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   key_load, key_nk  host key-load pulse and key length in words (4/6/8)
//   ke_k_ready, ke_nk one-cycle k_ready pulse and registered Nk to Key_Expansion
//   key_ok, key_err   key settled / sticky illegal-Nk flag
//   blk_valid, blk_ready   host block handshake
//   rk_addr, rk_valid round-key address and its availability
//   rnd_en, rnd_type  round strobe, 0 = initial, 1 = middle, 2 = final
//   out_valid, out_ready   result handshake
//   dec               (DECRYPT_EN only) walk round keys Nr down to 0
//
// Optional feature macro: DECRYPT_EN adds the dec input and descending order.
// ---------------------------------------------------------------------------
module aes_round_sched #(
    parameter int KEY_WAIT = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_load,
    input  logic [3:0]        key_nk,
    output logic              ke_k_ready,
    output logic [3:0]        ke_nk,
    output logic              key_ok,
    output logic              key_err,
    input  logic              blk_valid,
    output logic              blk_ready,
    output logic [ADDR_W-1:0] rk_addr,
    input  logic              rk_valid,
    output logic              rnd_en,
    output logic [1:0]        rnd_type,
    output logic              out_valid,
`ifdef DECRYPT_EN
    input  logic              dec,
`endif
    input  logic              out_ready
);

    typedef enum logic [2:0] {IDLE, KLOAD, KWAIT, READY, ROUND, DONE} state_t;

    state_t            state;
    logic [3:0]        nr;
    logic [7:0]        wait_cnt;
    logic              descending;
    logic              key_legal;
    logic [ADDR_W-1:0] nr_addr;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              at_first;
    logic              at_last;

    assign key_legal = (key_nk == 4'd4) || (key_nk == 4'd6) || (key_nk == 4'd8);
    assign nr_addr   = ADDR_W'(nr);

    // The walk direction decides which end of the key schedule is the
    // initial AddRoundKey and which one terminates the block.
    assign first_addr = descending ? nr_addr : '0;
    assign last_addr  = descending ? '0 : nr_addr;
    assign at_first   = (rk_addr == first_addr);
    assign at_last    = (rk_addr == last_addr);

    // A key load in the same cycle always wins over an offered block.
    assign blk_ready = (state == READY) && key_ok && !key_load;
    assign rnd_en    = (state == ROUND) && rk_valid;

    always_comb begin
        rnd_type = 2'd0;
        if (state == ROUND) begin
            if (at_first)
                rnd_type = 2'd0;
            else if (at_last)
                rnd_type = 2'd2;
            else
                rnd_type = 2'd1;
        end
    end

`ifdef DECRYPT_EN
    // Direction is latched at block accept and held for the whole block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            descending <= 1'b0;
        else if (blk_valid && blk_ready)
            descending <= dec;
    end
`else
    assign descending = 1'b0;
`endif

    // Main sequencer: key load/settle, block acceptance, round walk and
    // result hold. ke_k_ready defaults low so it is a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ke_k_ready <= 1'b0;
            ke_nk      <= 4'd0;
            key_ok     <= 1'b0;
            key_err    <= 1'b0;
            rk_addr    <= '0;
            out_valid  <= 1'b0;
            nr         <= 4'd0;
            wait_cnt   <= 8'd0;
        end else begin
            ke_k_ready <= 1'b0;
            case (state)
                IDLE, READY: begin
                    if (key_load) begin
                        key_ok <= 1'b0;
                        if (key_legal) begin
                            ke_nk      <= key_nk;
                            nr         <= key_nk + 4'd6;
                            key_err    <= 1'b0;
                            ke_k_ready <= 1'b1;
                            state      <= KLOAD;
                        end else begin
                            key_err <= 1'b1;
                            state   <= IDLE;
                        end
                    end else if (blk_valid && blk_ready) begin
`ifdef DECRYPT_EN
                        rk_addr <= dec ? nr_addr : '0;
`else
                        rk_addr <= '0;
`endif
                        state   <= ROUND;
                    end
                end
                KLOAD: begin
                    wait_cnt <= 8'(KEY_WAIT - 1);
                    state    <= KWAIT;
                end
                KWAIT: begin
                    if (wait_cnt == 8'd0) begin
                        key_ok <= 1'b1;
                        state  <= READY;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                ROUND: begin
                    // Without a round key the address simply holds (stall).
                    if (rk_valid) begin
                        if (at_last) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (descending) begin
                            rk_addr <= rk_addr - 1'b1;
                        end else begin
                            rk_addr <= rk_addr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= READY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
